// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: divided clock, period tick and a
// double-buffered ratio register that only changes at period boundaries.
module clk_div_prog #(
    parameter int unsigned W             = 8,
    parameter int unsigned DEFAULT_RATIO = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] ratio_in,
    input  logic         ratio_wr,
    output logic         clk_out,
    output logic         tick,
    output logic [W-1:0] ratio_cur,
    output logic         ratio_pend,
    output logic         ratio_err
);

    localparam logic [W-1:0] RATIO_RST = W'(DEFAULT_RATIO);
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] MIN_RATIO = W'(2);

    logic [W-1:0] cnt_q;
    logic [W-1:0] pend_val_q;

    logic [W-1:0] cnt_d;
    logic [W-1:0] pend_val_d;
    logic [W-1:0] ratio_cur_d;
    logic         ratio_pend_d;
    logic         ratio_err_d;
    logic         clk_out_d;
    logic         tick_d;

    logic         wr_ok;
    logic         at_end;
    logic         boundary;

    // Next-state: counter, ratio hand-over and registered outputs
    always_comb begin
        cnt_d        = cnt_q;
        pend_val_d   = pend_val_q;
        ratio_cur_d  = ratio_cur;
        ratio_pend_d = ratio_pend;
        ratio_err_d  = 1'b0;
        clk_out_d    = 1'b0;
        tick_d       = 1'b0;

        wr_ok    = ratio_wr && (ratio_in >= MIN_RATIO);
        at_end   = (cnt_q == (ratio_cur - ONE));
        // No period is running while disabled, so the ratio may switch freely
        boundary = !enable || at_end;

        if (ratio_wr && !wr_ok) begin
            ratio_err_d = 1'b1;
        end

        if (boundary) begin
            if (wr_ok) begin
                ratio_cur_d = ratio_in;
            end else if (ratio_pend) begin
                ratio_cur_d = pend_val_q;
            end
            ratio_pend_d = 1'b0;
        end else if (wr_ok) begin
            pend_val_d   = ratio_in;
            ratio_pend_d = 1'b1;
        end

        if (!enable || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // Outputs are derived from the next count so they line up with cnt
        if (enable) begin
            clk_out_d = (cnt_d >= (ratio_cur_d >> 1));
            tick_d    = (cnt_d == (ratio_cur_d - ONE));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            pend_val_q <= '0;
            ratio_cur  <= RATIO_RST;
            ratio_pend <= 1'b0;
            ratio_err  <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_val_q <= pend_val_d;
            ratio_cur  <= ratio_cur_d;
            ratio_pend <= ratio_pend_d;
            ratio_err  <= ratio_err_d;
            clk_out    <= clk_out_d;
            tick       <= tick_d;
        end
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider. It sits alongside the fixed clk_div (div2/4/8) stage and feeds peripherals that need arbitrary ratios.
- Generates a divided clock-like output (clk_out) and a one-cycle period strobe (tick), both fully synchronous to clk.
- The divide ratio is reprogrammable at runtime. Ratio changes are applied only at a period boundary, so clk_out never glitches or produces a short phase.

Parameters:
- W, 8: width of ratio and counter.
- DEFAULT_RATIO, 8: active ratio after reset; must satisfy 2 <= DEFAULT_RATIO <= 2^W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  divider run enable.
- ratio_in  in  W  requested divide ratio N.
- ratio_wr  in  1  one-cycle write strobe for ratio_in.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse in the last cycle of each period, registered.
- ratio_cur  out  W  currently active ratio.
- ratio_pend  out  1  a pending ratio is waiting for the next boundary.
- ratio_err  out  1  one-cycle pulse: the write was rejected.

Behaviour:
- Reset (async assert; deassert sampled on clk) sets:
  - cnt=0, clk_out=0, tick=0
  - ratio_cur=DEFAULT_RATIO
  - pending register=0, ratio_pend=0, ratio_err=0
- Counter: cnt runs 0..N-1 (N=ratio_cur), then wraps to 0. It advances once per clk while enable=1.
- Waveform: let L=floor(N/2). In the cycle where cnt==k, clk_out==1 iff k>=L.
  - Result: low for floor(N/2) cycles, high for ceil(N/2) cycles.
  - The rising edge appears in the cycle where cnt==L.
  - clk_out is a flop, computed from the next value of cnt, so it has zero lag relative to cnt.
- tick=1 exactly in the cycle where cnt==N-1 and enable=1. Otherwise tick=0.
- Ratio write (ratio_wr=1):
  - ratio_in<2: rejected; ratio_err=1 next cycle; pending register and ratio_pend unchanged.
  - ratio_in>=2: stored in the pending register; ratio_pend=1 next cycle.
  - A write while already pending overwrites the pending value (last write wins).
- Apply rule: when ratio_pend=1 and cnt==N-1 (the tick cycle), the next cycle has ratio_cur=pending, cnt=0 and ratio_pend=0. The new period starts low.
- Write in the tick cycle itself: the written value takes effect at that same boundary. Next cycle: ratio_cur=ratio_in, cnt=0, ratio_pend=0. A pending older value is discarded.
- enable=0:
  - Next cycle: cnt=0, clk_out=0, tick=0.
  - Writes are still accepted. A valid write (or an existing pending value) is applied in the next cycle, since no period is running; ratio_pend then clears.
  - On re-enable, counting restarts from cnt=0 (low phase).
- Reset mid-operation aborts the period immediately (clk_out=0 asynchronously) and discards any pending ratio.
- N=2: clk_out toggles every cycle (1 low, 1 high) and tick is high every second cycle.
- N=2^W-1: no overflow. The counter compare uses W bits and the wrap is at N-1.

Test Plan:
- Reset release, enable=1, default N=8 -> clk_out pattern 0000_1111 repeating; tick high at cnt=7, every 8 cycles; ratio_cur=8.
- At cnt=2 write ratio_in=5 -> ratio_pend=1; current period completes as 8 cycles; next periods are 00111 (L=2) with tick every 5; ratio_pend clears at the boundary.
- Write ratio_in=1, then ratio_in=0 -> ratio_err pulses once each; ratio_cur and ratio_pend unchanged; waveform undisturbed.
- Write 6 at cnt=1, then 3 at cnt=4 (N=8) -> only 3 applied at the boundary; following periods are 011.
- Write ratio_in=2 in the tick cycle -> next cycle cnt=0, ratio_cur=2, clk_out alternates 0,1; ratio_pend never asserts.
- Assert reset while clk_out=1 at N=5 -> clk_out=0 immediately, ratio_cur=8, ratio_pend=0. Separately, drop enable at cnt=5 -> next cycle clk_out=0, tick=0; re-enable restarts at cnt=0 with a full low phase.
